// File: rtl/cordic_sincos_stream.sv
// cordic_sincos_stream: iterative full-circle CORDIC producing sine and cosine
// of one unsigned angle word, with valid/ready handshakes and a tag carried
// from request to result.
//
// The angle is folded into [0, pi/2) by peeling off the two quadrant bits. The
// inner angle is rotated one micro-step per cycle, and the result is unfolded
// back into the original quadrant.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready only while idle)
//   in_angle, in_tag      angle (2^BIT_WIDTH = 2*pi) and channel tag
//   out_valid/out_ready   result handshake; result held until consumed
//   out_cos, out_sin      signed results, 2^(BIT_WIDTH-2) = +1.0
//   out_tag               tag of the request that produced the result
//   busy                  engine is not idle
module cordic_sincos_stream #(
  parameter int BIT_WIDTH  = 16,
  parameter int ITERATIONS = BIT_WIDTH - 2,
  parameter int GUARD      = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_angle,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_cos,
  output logic [BIT_WIDTH-1:0] out_sin,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam int IW   = BIT_WIDTH + GUARD + 1;  // signed x/y/z width
  localparam int FRAC = BIT_WIDTH - 2 + GUARD;  // internal 1.0 = quarter turn
  localparam int CW   = $clog2(ITERATIONS);
  localparam int NTAB = 2 ** CW;                // table covers every counter code

  function automatic real pow2_real(input int n);
    real r;
    r = 1.0;
    for (int k = 0; k < n; k++) r = r * 2.0;
    return r;
  endfunction

  // atan(2^-i) by power series; atan(1) is taken directly since the series
  // converges too slowly there.
  function automatic real atan_pow2(input int i);
    real x, term, sum;
    if (i == 0) return 0.78539816339744831;
    x = 1.0 / pow2_real(i);
    term = x;
    sum  = 0.0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) sum = sum + term / (2.0 * k + 1.0);
      else            sum = sum - term / (2.0 * k + 1.0);
      term = term * x * x;
    end
    return sum;
  endfunction

  // Angles in units of a quarter turn scaled by 2^FRAC.
  function automatic logic [NTAB-1:0][IW-1:0] atan_table();
    logic [NTAB-1:0][IW-1:0] t;
    for (int i = 0; i < NTAB; i++)
      t[i] = IW'(longint'(atan_pow2(i) * pow2_real(FRAC) / 1.5707963267948966));
    return t;
  endfunction

  localparam logic [NTAB-1:0][IW-1:0] ATAN_TAB = atan_table();
  localparam logic signed [IW-1:0]    K0  = IW'(longint'(0.6072529350 * pow2_real(FRAC)));
  localparam logic signed [IW-1:0]    RND = IW'(1) << (GUARD - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, UNFOLD, HOLD} state_t;
  state_t state, state_n;

  logic signed [IW-1:0]  x, y, z;
  logic [CW-1:0]         iter;
  logic [1:0]            quad;
  logic [TAG_WIDTH-1:0]  tag;

  logic                  accept, last_iter;

  assign in_ready  = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (iter == CW'(ITERATIONS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = ROTATE;
      ROTATE:  if (last_iter) state_n = UNFOLD;
      UNFOLD:  state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One micro-rotation; direction chosen by the sign of the residual angle.
  logic                 dir;
  logic signed [IW-1:0] x_sh, y_sh, at, x_n, y_n, z_n;

  always_comb begin
    dir  = ~z[IW-1];
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    at   = ATAN_TAB[iter];
    x_n  = dir ? x - y_sh : x + y_sh;
    y_n  = dir ? y + x_sh : y - x_sh;
    z_n  = dir ? z - at   : z + at;
  end

  // Round-half-up the guard bits. Results stay within +/-(2^(BIT_WIDTH-2)+4),
  // so the low BIT_WIDTH bits hold them and negation cannot overflow.
  logic signed [IW-1:0]        x_sum, y_sum;
  logic signed [BIT_WIDTH-1:0] xr, yr, c_n, s_n;
  logic                        unused_bits;

  always_comb begin
    x_sum = x + RND;
    y_sum = y + RND;
    xr    = x_sum[GUARD +: BIT_WIDTH];
    yr    = y_sum[GUARD +: BIT_WIDTH];
    c_n   = xr;
    s_n   = yr;
    case (quad)
      2'd1: begin c_n = -yr; s_n =  xr; end
      2'd2: begin c_n = -xr; s_n = -yr; end
      2'd3: begin c_n =  yr; s_n = -xr; end
      default: ;
    endcase
  end

  assign unused_bits = ^{x_sum[IW-1], x_sum[GUARD-1:0], y_sum[IW-1], y_sum[GUARD-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      quad      <= '0;
      tag       <= '0;
      out_valid <= 1'b0;
      out_cos   <= '0;
      out_sin   <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          quad <= in_angle[BIT_WIDTH-1 -: 2];
          tag  <= in_tag;
          x    <= K0;
          y    <= '0;
          z    <= {3'b000, in_angle[BIT_WIDTH-3:0], {GUARD{1'b0}}};
          iter <= '0;
        end
        ROTATE: begin
          x    <= x_n;
          y    <= y_n;
          z    <= z_n;
          iter <= last_iter ? '0 : iter + 1'b1;
        end
        UNFOLD: begin
          out_cos   <= c_n;
          out_sin   <= s_n;
          out_tag   <= tag;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
